reg_wb_queue: RTL and testbench

//  Write-back queue that drives the register file's write port (rd/busW/reg_wr, r_type=1).

---
 rtl/reg_wb_queue_if.sv | 25 ++
 rtl/reg_wb_queue.sv | 120 ++++++++++++
 tb/tb_reg_wb_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_queue_if.sv
// Write-back queue bus: producer request handshake plus the register-file
// write port. The queue sits on the slave side; producers and the register
// file together form the master side.
interface reg_wb_queue_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_rd;
  logic [DATA_W-1:0] req_data;
  logic              wb_hold;
  logic              wb_reg_wr;
  logic [4:0]        wb_rw;
  logic [DATA_W-1:0] wb_busW;

  modport master (
    output req_valid, req_rd, req_data, wb_hold,
    input  req_ready, wb_reg_wr, wb_rw, wb_busW
  );

  modport slave (
    input  req_valid, req_rd, req_data, wb_hold,
    output req_ready, wb_reg_wr, wb_rw, wb_busW
  );
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: DEPTH-entry FIFO of {rd, data} register writes that retires
// at most one entry per cycle into the register file, in push order.
// Optional read-side forwarding of queued data is enabled by defining
// WB_QUEUE_BYPASS_EN; it adds the fwd_* ports.
module reg_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  reg_wb_queue_if.slave    bus,
  output logic [PTR_W:0]   count
`ifdef WB_QUEUE_BYPASS_EN
  ,
  input  logic [4:0]        fwd_rs,
  input  logic [4:0]        fwd_rs2,
  output logic              fwd_a_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_b_data
`endif
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [4:0]        rd_mem_q   [DEPTH];
  logic [4:0]        rd_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  logic not_empty;
  logic full;
  logic push;
  logic pop;

  // Handshake and retire decisions; flush blocks both in the same cycle.
  assign not_empty = (count_q != '0);
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign push      = bus.req_valid && !full && !flush;
  assign pop       = not_empty && !bus.wb_hold && !flush;

  assign bus.req_ready = !full && !flush;
  assign bus.wb_reg_wr = pop;
  assign bus.wb_rw     = not_empty ? rd_mem_q[rd_ptr_q]   : '0;
  assign bus.wb_busW   = not_empty ? data_mem_q[rd_ptr_q] : '0;
  assign count         = count_q;

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        rd_mem_d[wr_ptr_q]   = bus.req_rd;
        data_mem_d[wr_ptr_q] = bus.req_data;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // State registers; reset discards every pending entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

`ifdef WB_QUEUE_BYPASS_EN
  logic [PTR_W-1:0] fwd_idx;

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    fwd_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (((PTR_W+1)'(k) < count_q) && !flush) begin
        if (rd_mem_q[fwd_idx] == fwd_rs) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = data_mem_q[fwd_idx];
        end
        if (rd_mem_q[fwd_idx] == fwd_rs2) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = data_mem_q[fwd_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, single write latency, full/stall,
// streaming across pointer wrap, flush, reset mid-traffic and (when
// WB_QUEUE_BYPASS_EN is defined) forwarding.
module tb_reg_wb_queue;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int DATA_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [PTR_W:0]   count;
`ifdef WB_QUEUE_BYPASS_EN
  logic [4:0]        fwd_rs, fwd_rs2;
  logic              fwd_a_hit, fwd_b_hit;
  logic [DATA_W-1:0] fwd_a_data, fwd_b_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] wlog[$];

  always #5 clk = ~clk;

  reg_wb_queue_if #(.DATA_W(DATA_W)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
`ifdef WB_QUEUE_BYPASS_EN
    ,
    .fwd_rs     (fwd_rs),
    .fwd_rs2    (fwd_rs2),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_b_data (fwd_b_data)
`endif
  );

  // Register-file model: capture every write on the edge it happens.
  always @(posedge clk) begin
    if (reset && bus.wb_reg_wr) wlog.push_back({bus.wb_rw, bus.wb_busW});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [4:0]  exp_rd [5];
    logic [31:0] exp_dt [5];

    reset = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.wb_hold   = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
    fwd_rs  = '0;
    fwd_rs2 = '0;
`endif
    #3;
    chk("rst_count", count, 0);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_wr", bus.wb_reg_wr, 0);
    chk("rst_rw", bus.wb_rw, 0);
    chk("rst_busW", bus.wb_busW, 0);
    step();
    reset = 1'b1;
    step();

    // Single write: one-cycle latency, then empty again.
    bus.req_valid = 1'b1; bus.req_rd = 5'd5; bus.req_data = 32'hDEADBEEF;
    #1 chk("t2_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    #1;
    chk("t2_count1", count, 1);
    chk("t2_wr", bus.wb_reg_wr, 1);
    chk("t2_rw", bus.wb_rw, 5);
    chk("t2_busW", bus.wb_busW, 32'hDEADBEEF);
    step();
    #1;
    chk("t2_count0", count, 0);
    chk("t2_wr_idle", bus.wb_reg_wr, 0);
    chk("t2_rw_idle", bus.wb_rw, 0);
    chk("t2_busW_idle", bus.wb_busW, 0);
    chk("t2_nlog", wlog.size(), 1);
    chk("t2_log", wlog[0], {5'd5, 32'hDEADBEEF});

    // Fill while held, stall a 5th request, then drain.
    base = wlog.size();
    bus.wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.req_valid = 1'b1; bus.req_rd = 5'(i); bus.req_data = 32'h100 + 32'(i);
      step();
    end
    bus.req_rd = 5'd9; bus.req_data = 32'h999;
    #1;
    chk("t3_full_count", count, 4);
    chk("t3_full_ready", bus.req_ready, 0);
    chk("t3_held_wr", bus.wb_reg_wr, 0);
    step();
    #1 chk("t3_stall_count", count, 4);
    bus.wb_hold = 1'b0;
    #1;
    chk("t3_wr1", bus.wb_reg_wr, 1);
    chk("t3_rw1", bus.wb_rw, 1);
    chk("t3_ready_full_pop", bus.req_ready, 0);
    step();
    #1;
    chk("t3_count_a", count, 3);
    chk("t3_rw2", bus.wb_rw, 2);
    chk("t3_ready_after_pop", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    #1;
    chk("t3_count_b", count, 3);
    chk("t3_rw3", bus.wb_rw, 3);
    step();
    #1;
    chk("t3_count_c", count, 2);
    chk("t3_rw4", bus.wb_rw, 4);
    step();
    #1;
    chk("t3_count_d", count, 1);
    chk("t3_rw9", bus.wb_rw, 9);
    chk("t3_busW9", bus.wb_busW, 32'h999);
    step();
    #1 chk("t3_count_e", count, 0);
    exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
    exp_dt = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h999};
    chk("t3_nlog", wlog.size(), base + 5);
    for (int i = 0; i < 5; i++) chk("t3_log", wlog[base+i], {exp_rd[i], exp_dt[i]});

    // Streaming push+pop across pointer wrap.
    base = wlog.size();
    for (int i = 1; i <= 10; i++) begin
      bus.req_valid = 1'b1; bus.req_rd = 5'(i); bus.req_data = 32'(i) * 32'h11;
      #1;
      if (i > 1) begin
        chk("t4_count", count, 1);
        chk("t4_rw", bus.wb_rw, 64'(i - 1));
      end
      step();
    end
    bus.req_valid = 1'b0;
    #1;
    chk("t4_count_last", count, 1);
    chk("t4_rw_last", bus.wb_rw, 10);
    step();
    #1 chk("t4_count_end", count, 0);
    chk("t4_nlog", wlog.size(), base + 10);
    for (int i = 0; i < 10; i++) chk("t4_log", wlog[base+i], {5'(i + 1), 32'(i + 1) * 32'h11});

    // Flush with two queued and a live request.
    bus.wb_hold = 1'b1;
    bus.req_valid = 1'b1; bus.req_rd = 5'd7; bus.req_data = 32'h77;
    step();
    bus.req_rd = 5'd8; bus.req_data = 32'h88;
    step();
    base = wlog.size();
    bus.req_rd = 5'd31; bus.req_data = 32'hFF;
    flush = 1'b1;
    bus.wb_hold = 1'b0;
    #1;
    chk("t5_count_pre", count, 2);
    chk("t5_ready", bus.req_ready, 0);
    chk("t5_wr", bus.wb_reg_wr, 0);
    step();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_wr_after", bus.wb_reg_wr, 0);
    step();
    step();
    chk("t5_nlog", wlog.size(), base);

    // Reset while three entries are queued.
    bus.wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_rd = 5'(10 + i); bus.req_data = 32'hA0 + 32'(i);
      step();
    end
    bus.req_valid = 1'b0;
    #1 chk("t1_count_pre", count, 3);
    base = wlog.size();
    reset = 1'b0;
    bus.wb_hold = 1'b0;
    #1;
    chk("t1_count", count, 0);
    chk("t1_wr", bus.wb_reg_wr, 0);
    chk("t1_ready", bus.req_ready, 1);
    step();
    reset = 1'b1;
    step();
    step();
    chk("t1_nlog", wlog.size(), base);
    chk("t1_count_post", count, 0);

`ifdef WB_QUEUE_BYPASS_EN
    // Forwarding: youngest matching entry wins; flush hides hits.
    bus.wb_hold = 1'b1;
    bus.req_valid = 1'b1; bus.req_rd = 5'd3; bus.req_data = 32'hA;
    step();
    bus.req_data = 32'hB;
    step();
    bus.req_valid = 1'b0;
    fwd_rs = 5'd3; fwd_rs2 = 5'd4;
    #1;
    chk("t6_a_hit", fwd_a_hit, 1);
    chk("t6_a_data", fwd_a_data, 32'hB);
    chk("t6_b_hit", fwd_b_hit, 0);
    chk("t6_b_data", fwd_b_data, 0);
    flush = 1'b1;
    #1 chk("t6_flush_hit", fwd_a_hit, 0);
    step();
    flush = 1'b0;
    bus.wb_hold = 1'b0;
    #1 chk("t6_count", count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
